// File: rtl/ppi_pkg.sv
// Shared constants and types for the PPI Group B controller.
// Control-word field positions, mode encodings and handshake states.
package ppi_pkg;

    localparam int CW_MODE_FLAG = 7;
    localparam int CW_MODE_BIT  = 2;
    localparam int CW_PB_DIR    = 1;
    localparam int CW_PCL_DIR   = 0;

    localparam int BSR_IDX_HI = 3;
    localparam int BSR_IDX_LO = 1;
    localparam int BSR_VAL    = 0;

    localparam logic MODE_0 = 1'b0;
    localparam logic MODE_1 = 1'b1;

    localparam logic [2:0] BSR_IDX_INTE = 3'd2;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_FULL = 2'd1,
        HS_ACKD = 2'd2
    } hs_state_t;

endpackage

// File: rtl/ppi_edge_sync.sv
// Synchroniser for an asynchronous active-low pad strobe.
// Emits one-cycle fall/rise pulses after STAGES flops.
module ppi_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_i,
    output logic fall_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Idle level of the pad is high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pad_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign fall_o = prev_q & ~sync_q[STAGES-1];
    assign rise_o = ~prev_q & sync_q[STAGES-1];

endmodule

// File: rtl/ppi_group_b_seq.sv
// PPI Group B controller: control-word decode, Port B / Port C-lower
// latches and Mode 1 strobed handshake on PC2..PC0.
module ppi_group_b_seq
    import ppi_pkg::*;
#(
    parameter int DW          = 8,
    parameter int PCL_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_ctrl,
    input  logic [7:0]       cpu_data,
    input  logic             wr_b,
    input  logic             rd_b,
    input  logic [DW-1:0]    pb_in,
    input  logic             stb_n,
    input  logic             ack_n,
    output logic             pb_dir_in,
    output logic             pcl_dir_in,
    output logic             mode1_b,
    output logic [DW-1:0]    pb_out,
    output logic [DW-1:0]    pb_rd_data,
    output logic [PCL_W-1:0] pcl_out,
    output logic             ibf,
    output logic             obf_n,
    output logic             intr_b,
    output logic             ovr_b
);

    logic stb_fall;
    logic stb_rise;
    logic ack_fall;
    logic ack_rise;

    ppi_edge_sync #(.STAGES(SYNC_STAGES)) u_stb_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pad_i  (stb_n),
        .fall_o (stb_fall),
        .rise_o (stb_rise)
    );

    ppi_edge_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pad_i  (ack_n),
        .fall_o (ack_fall),
        .rise_o (ack_rise)
    );

    logic             mode1_q,  mode1_d;
    logic             pb_dir_q, pb_dir_d;
    logic             pcl_dir_q, pcl_dir_d;
    logic [DW-1:0]    pb_out_q, pb_out_d;
    logic [DW-1:0]    hold_q,   hold_d;
    logic [DW-1:0]    pb_smp_q;
    logic [PCL_W-1:0] pcl_q,    pcl_d;
    logic             ibf_q,    ibf_d;
    logic             obf_n_q,  obf_n_d;
    logic             pend_q,   pend_d;
    logic             ovr_q,    ovr_d;
    logic             inte_q,   inte_d;
    hs_state_t        st_q,     st_d;

    logic [2:0] bsr_idx;
    logic       bsr_val;
    logic       unused_cw;

    assign bsr_idx   = cpu_data[BSR_IDX_HI:BSR_IDX_LO];
    assign bsr_val   = cpu_data[BSR_VAL];
    assign unused_cw = ^cpu_data[6:4];

    always_comb begin
        mode1_d   = mode1_q;
        pb_dir_d  = pb_dir_q;
        pcl_dir_d = pcl_dir_q;
        pb_out_d  = pb_out_q;
        hold_d    = hold_q;
        pcl_d     = pcl_q;
        ibf_d     = ibf_q;
        obf_n_d   = obf_n_q;
        pend_d    = pend_q;
        ovr_d     = ovr_q;
        inte_d    = inte_q;
        st_d      = st_q;

        if (wr_ctrl) begin
            if (cpu_data[CW_MODE_FLAG]) begin
                mode1_d   = cpu_data[CW_MODE_BIT];
                pb_dir_d  = cpu_data[CW_PB_DIR];
                pcl_dir_d = cpu_data[CW_PCL_DIR];
                pb_out_d  = '0;
                pcl_d     = '0;
                ibf_d     = 1'b0;
                obf_n_d   = 1'b1;
                pend_d    = 1'b0;
                ovr_d     = 1'b0;
                inte_d    = 1'b0;
                st_d      = HS_IDLE;
            end else begin
                if (mode1_q == MODE_1 && bsr_idx == BSR_IDX_INTE)
                    inte_d = bsr_val;
                // In Mode 1 only PC3 stays CPU-owned; PC0/PC1 belong to the handshake.
                for (int i = 0; i < PCL_W; i++) begin
                    if (bsr_idx == i[2:0] && (mode1_q == MODE_0 || i == 3))
                        pcl_d[i] = bsr_val;
                end
            end
        end else if (mode1_q == MODE_0) begin
            if (wr_b && !pb_dir_q)
                pb_out_d = cpu_data[DW-1:0];
        end else if (pb_dir_q) begin
            unique case (st_q)
                HS_IDLE: begin
                    if (stb_fall) begin
                        hold_d = pb_in;
                        ibf_d  = 1'b1;
                        st_d   = HS_FULL;
                    end
                end
                HS_FULL: begin
                    if (stb_fall) begin
                        hold_d = pb_in;
                        ovr_d  = !rd_b;
                        if (rd_b)
                            pend_d = 1'b0;
                    end else if (rd_b) begin
                        ibf_d  = 1'b0;
                        pend_d = 1'b0;
                        ovr_d  = 1'b0;
                        st_d   = HS_IDLE;
                    end else if (stb_rise) begin
                        pend_d = 1'b1;
                    end
                end
                default: st_d = HS_IDLE;
            endcase
        end else begin
            if (wr_b) begin
                pb_out_d = cpu_data[DW-1:0];
                obf_n_d  = 1'b0;
                pend_d   = 1'b0;
                st_d     = HS_FULL;
            end else begin
                unique case (st_q)
                    HS_FULL: begin
                        if (ack_fall) begin
                            obf_n_d = 1'b1;
                            st_d    = HS_ACKD;
                        end
                    end
                    HS_ACKD: begin
                        if (ack_rise) begin
                            pend_d = 1'b1;
                            st_d   = HS_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode1_q   <= MODE_0;
            pb_dir_q  <= 1'b1;
            pcl_dir_q <= 1'b1;
            pb_out_q  <= '0;
            hold_q    <= '0;
            pb_smp_q  <= '0;
            pcl_q     <= '0;
            ibf_q     <= 1'b0;
            obf_n_q   <= 1'b1;
            pend_q    <= 1'b0;
            ovr_q     <= 1'b0;
            inte_q    <= 1'b0;
            st_q      <= HS_IDLE;
        end else begin
            mode1_q   <= mode1_d;
            pb_dir_q  <= pb_dir_d;
            pcl_dir_q <= pcl_dir_d;
            pb_out_q  <= pb_out_d;
            hold_q    <= hold_d;
            pb_smp_q  <= pb_in;
            pcl_q     <= pcl_d;
            ibf_q     <= ibf_d;
            obf_n_q   <= obf_n_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            inte_q    <= inte_d;
            st_q      <= st_d;
        end
    end

    // Pending request is kept separately so re-enabling INTE re-raises it.
    assign intr_b     = pend_q & inte_q;
    assign mode1_b    = mode1_q;
    assign pb_dir_in  = pb_dir_q;
    assign pcl_dir_in = pcl_dir_q;
    assign pb_out     = pb_out_q;
    assign ibf        = ibf_q;
    assign obf_n      = obf_n_q;
    assign ovr_b      = ovr_q;

    always_comb begin
        if (!pb_dir_q)
            pb_rd_data = pb_out_q;
        else if (mode1_q == MODE_1)
            pb_rd_data = hold_q;
        else
            pb_rd_data = pb_smp_q;
    end

    always_comb begin
        pcl_out = pcl_q;
        if (mode1_q == MODE_1) begin
            pcl_out[0] = intr_b;
            pcl_out[1] = pb_dir_q ? ibf_q : obf_n_q;
        end
    end

endmodule
